dsp_acc_reduce: RTL and testbench

Downstream consumer of the 20x18 unsigned DSP multiplier stage in the qlf_k6n10f DSP flow. It accepts a stream of 38-bit unsigned products over a valid/ready handshake, sums a programmed number of them into a wide saturating accumulator, and presents one dot-product result per job on a valid/ready output. It is the reduction stage used by the post-synthesis DSP simulation benches that chain multiply and accumulate.

---
 rtl/dsp_acc_pkg.sv | 23 ++
 rtl/dsp_sat_add.sv | 27 ++
 rtl/dsp_acc_reduce.sv | 141 ++++++++++++++
 tb/tb_dsp_acc_reduce.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsp_acc_pkg
// Purpose  : Shared types and default widths for the DSP accumulate/reduce
//            stage that follows the 20x18 unsigned multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package dsp_acc_pkg;

    // Default widths: product from the multiplier, accumulator/result, job length
    localparam int PROD_W = 38;
    localparam int ACC_W  = 48;
    localparam int LEN_W  = 8;

    // Job sequencing states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } acc_state_t;

endpackage : dsp_acc_pkg
`default_nettype wire

// File: rtl/dsp_sat_add.sv
`default_nettype none
// ============================================================================
// Module   : dsp_sat_add
// Purpose  : Combinational unsigned saturating adder. A carry out of the
//            W-bit sum clamps the result to all-ones and raises ovf.
// Revision : 1.0 - initial release
// ============================================================================
module dsp_sat_add #(
    parameter int W = 48
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] w_full;

    // One extra bit catches the carry; an all-ones input stays all-ones on any add
    always_comb begin
        w_full = {1'b0, a} + {1'b0, b};
        ovf    = w_full[W];
        sum    = w_full[W] ? {W{1'b1}} : w_full[W-1:0];
    end

endmodule : dsp_sat_add
`default_nettype wire

// File: rtl/dsp_acc_reduce.sv
`default_nettype none
// ============================================================================
// Module   : dsp_acc_reduce
// Purpose  : Sums a programmed number of unsigned products into a saturating
//            accumulator and presents one dot-product result per job over a
//            valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module dsp_acc_reduce #(
    parameter int PROD_W = dsp_acc_pkg::PROD_W,
    parameter int ACC_W  = dsp_acc_pkg::ACC_W,
    parameter int LEN_W  = dsp_acc_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_sat,
    output logic              busy
);

    import dsp_acc_pkg::*;

    acc_state_t         r_state;
    acc_state_t         w_next;
    logic [LEN_W-1:0]   r_remaining;
    logic [ACC_W-1:0]   r_acc;
    logic               r_sat;
    logic [ACC_W-1:0]   r_sum;
    logic               r_sum_sat;

    logic [ACC_W-1:0]   w_prod_ext;
    logic [ACC_W-1:0]   w_add_sum;
    logic               w_add_ovf;
    logic               w_take;
    logic               w_last;
    logic               w_sat_next;

    assign w_prod_ext = ACC_W'(in_prod);
    // in_ready is only high in ACC, so this is the input handshake
    assign w_take     = (r_state == ACC) && in_valid;
    assign w_last     = (r_remaining == LEN_W'(1));
    assign w_sat_next = r_sat | w_add_ovf;

    dsp_sat_add #(
        .W   (ACC_W)
    ) u_sat_add (
        .a   (r_acc),
        .b   (w_prod_ext),
        .sum (w_add_sum),
        .ovf (w_add_ovf)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; start is only looked at in IDLE and is never queued
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (len == '0) ? HOLD : ACC;
                end
            end
            ACC: begin
                if (w_take && w_last) begin
                    w_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Handshake outputs decode the registered state only (no in_valid->in_ready path)
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            IDLE:    busy      = 1'b0;
            ACC:     in_ready  = 1'b1;
            HOLD:    out_valid = 1'b1;
            default: busy      = 1'b0;
        endcase
    end

    // Accumulator, sticky saturation flag and remaining-term counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_remaining <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_remaining <= len;
        end else if (w_take) begin
            r_acc       <= w_add_sum;
            r_sat       <= w_sat_next;
            r_remaining <= r_remaining - LEN_W'(1);
        end
    end

    // Result registers: loaded only when a job completes so the published sum
    // keeps its last value while the next job accumulates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum     <= '0;
            r_sum_sat <= 1'b0;
        end else if ((r_state == IDLE) && start && (len == '0)) begin
            r_sum     <= '0;
            r_sum_sat <= 1'b0;
        end else if (w_take && w_last) begin
            r_sum     <= w_add_sum;
            r_sum_sat <= w_sat_next;
        end
    end

    assign out_sum = r_sum;
    assign out_sat = r_sum_sat;

endmodule : dsp_acc_reduce
`default_nettype wire

// File: tb/tb_dsp_acc_reduce.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_acc_reduce
// Purpose  : Self-checking bench for dsp_acc_reduce. Two instances (48-bit and
//            40-bit accumulators) share the same stimulus; table vectors,
//            hand-written corner sequences and random jobs checked against a
//            plain-arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsp_acc_reduce;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [37:0] in_prod;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_sat_a, busy_a;
    logic [47:0] out_sum_a;
    logic        in_ready_b, out_valid_b, out_sat_b, busy_b;
    logic [39:0] out_sum_b;

    int checks   = 0;
    int failures = 0;

    dsp_acc_reduce #(.PROD_W(38), .ACC_W(48), .LEN_W(8)) u_dut48 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_prod(in_prod),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_sum(out_sum_a),
        .out_sat(out_sat_a), .busy(busy_a)
    );

    dsp_acc_reduce #(.PROD_W(38), .ACC_W(40), .LEN_W(8)) u_dut40 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_prod(in_prod),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_sum(out_sum_b),
        .out_sat(out_sat_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: all terms are non-negative, so sequential saturation equals
    // clamping the exact total; the flag is set iff the total exceeds the range
    function automatic void ref_job(input logic [37:0] p[$], input int accw,
                                    output longint unsigned s, output bit sat);
        longint unsigned total = 0;
        longint unsigned maxv  = (64'd1 << accw) - 64'd1;
        foreach (p[i]) total += 64'(p[i]);
        if (total > maxv) begin s = maxv;  sat = 1'b1; end
        else              begin s = total; sat = 1'b0; end
    endfunction

    task automatic chk_out(input string nm, input longint unsigned e48, input bit s48,
                           input longint unsigned e40, input bit s40);
        chk({nm, ".valid48"}, out_valid_a, 1);
        chk({nm, ".valid40"}, out_valid_b, 1);
        chk({nm, ".sum48"},   out_sum_a,   e48);
        chk({nm, ".sat48"},   out_sat_a,   s48);
        chk({nm, ".sum40"},   out_sum_b,   e40);
        chk({nm, ".sat40"},   out_sat_b,   s40);
        chk({nm, ".rdy_hold"}, in_ready_a, 0);
    endtask

    task automatic run_job(input string nm, input int n, input logic [37:0] p[$],
                           input int gap, input int bp, input bit ign,
                           input longint unsigned e48, input bit s48,
                           input longint unsigned e40, input bit s40);
        int wc;
        if (n == 0) begin
            in_valid = 1'b1;
            in_prod  = 38'd7;
        end
        start = 1'b1;
        len   = 8'(n);
        step();
        start = 1'b0;
        len   = 8'd0;
        chk({nm, ".busy"}, busy_a, 1);
        if (n == 0) begin
            chk({nm, ".rdy_empty"}, in_ready_a, 0);
        end else begin
            chk({nm, ".rdy48"}, in_ready_a, 1);
            chk({nm, ".rdy40"}, in_ready_b, 1);
            chk({nm, ".early_valid"}, out_valid_a, 0);
            for (int i = 0; i < n; i++) begin
                if (ign && i == 1) begin
                    in_valid = 1'b0;
                    start    = 1'b1;
                    len      = 8'd1;
                    step();
                    start    = 1'b0;
                    len      = 8'd0;
                end
                if (i > 0) begin
                    for (int g = 0; g < gap; g++) begin
                        in_valid = 1'b0;
                        step();
                    end
                end
                in_valid = 1'b1;
                in_prod  = p[i];
                wc = 0;
                while (!in_ready_a && wc < 20) begin
                    step();
                    wc++;
                end
                if (wc >= 20) begin
                    checks++;
                    failures++;
                    $display("FAIL %s.handshake_timeout: in_ready=%0d expected 1", nm, in_ready_a);
                    in_valid = 1'b0;
                    break;
                end
                step();
            end
            in_valid = 1'b0;
        end
        chk_out(nm, e48, s48, e40, s40);
        for (int c = 0; c < bp; c++) begin
            out_ready = 1'b0;
            step();
            chk_out({nm, ".bp"}, e48, s48, e40, s40);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({nm, ".valid_after"}, out_valid_a, 0);
        chk({nm, ".busy_after"},  busy_a,      0);
    endtask

    typedef struct {
        string           nm;
        int              n;
        logic [37:0]     p [6];
        int              gap;
        int              bp;
        bit              ign;
        longint unsigned e48;
        bit              s48;
        longint unsigned e40;
        bit              s40;
    } vec_t;

    localparam longint unsigned M38  = (64'd1 << 38) - 64'd1;
    localparam longint unsigned MAX40 = (64'd1 << 40) - 64'd1;

    initial begin
        vec_t            vt [7];
        logic [37:0]     q [$];
        logic [37:0]     m38v;
        logic [37:0]     pmv;
        longint unsigned pm;
        longint unsigned r48, r40;
        bit              t48, t40;
        logic [63:0]     rnd;

        m38v = M38[37:0];
        pm   = 64'd1048575 * 64'd262143;
        pmv  = pm[37:0];

        vt[0] = '{"basic",   3, '{38'd6, 38'd10, 38'd4, 0, 0, 0},  0, 0, 0,
                  64'd20, 0, 64'd20, 0};
        vt[1] = '{"bubbles", 2, '{38'd1, 38'd2, 0, 0, 0, 0},       3, 4, 0,
                  64'd3, 0, 64'd3, 0};
        vt[2] = '{"three_max", 3, '{m38v, m38v, m38v, 0, 0, 0},    0, 1, 0,
                  64'd3 * M38, 0, 64'd3 * M38, 0};
        vt[3] = '{"sat6",    6, '{m38v, m38v, m38v, m38v, m38v, m38v}, 0, 2, 0,
                  64'd6 * M38, 0, MAX40, 1};
        vt[4] = '{"after_sat", 1, '{38'd5, 0, 0, 0, 0, 0},         0, 0, 0,
                  64'd5, 0, 64'd5, 0};
        vt[5] = '{"empty",   0, '{0, 0, 0, 0, 0, 0},               0, 1, 0,
                  64'd0, 0, 64'd0, 0};
        vt[6] = '{"ign_start", 3, '{38'd100, 38'd200, 38'd300, 0, 0, 0}, 1, 0, 1,
                  64'd600, 0, 64'd600, 0};

        rst_n = 1'b0; start = 1'b0; len = 8'd0;
        in_valid = 1'b0; in_prod = 38'd0; out_ready = 1'b0;
        repeat (3) step();
        chk("reset.in_ready",  in_ready_a,  0);
        chk("reset.out_valid", out_valid_a, 0);
        chk("reset.out_sum",   out_sum_a,   0);
        chk("reset.out_sat",   out_sat_a,   0);
        chk("reset.busy",      busy_a,      0);
        chk("reset.busy40",    busy_b,      0);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 7; v++) begin
            q = {};
            for (int k = 0; k < vt[v].n; k++) q.push_back(vt[v].p[k]);
            run_job(vt[v].nm, vt[v].n, q, vt[v].gap, vt[v].bp, vt[v].ign,
                    vt[v].e48, vt[v].s48, vt[v].e40, vt[v].s40);
        end

        // Longest job with the largest multiplier product on every term
        q = {};
        for (int k = 0; k < 255; k++) q.push_back(pmv);
        run_job("max_len", 255, q, 0, 0, 0, 64'd255 * pm, 0, MAX40, 1);

        // Reset in the middle of a 4-term job; previous result is non-zero
        start = 1'b1; len = 8'd4;
        step();
        start = 1'b0; len = 8'd0;
        in_valid = 1'b1; in_prod = 38'd11;
        step();
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.in_ready",  in_ready_a,  0);
        chk("midrst.busy",      busy_a,      0);
        chk("midrst.out_valid", out_valid_a, 0);
        chk("midrst.out_sum",   out_sum_a,   0);
        chk("midrst.out_sat40", out_sat_b,   0);
        step();
        step();
        rst_n = 1'b1;
        step();
        q = {38'd9};
        run_job("post_rst", 1, q, 0, 0, 0, 64'd9, 0, 64'd9, 0);

        // Random jobs against the arithmetic reference
        for (int j = 0; j < 40; j++) begin
            int n;
            n = int'($urandom_range(0, 12));
            q = {};
            for (int k = 0; k < n; k++) begin
                rnd = {$urandom(), $urandom()};
                if ($urandom_range(0, 1) == 0) q.push_back(38'($urandom_range(0, 100000)));
                else                           q.push_back(rnd[37:0]);
            end
            ref_job(q, 48, r48, t48);
            ref_job(q, 40, r40, t40);
            run_job($sformatf("rand%0d", j), n, q, int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)), 1'b0, r48, t48, r40, t40);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dsp_acc_reduce
`default_nettype wire
